hb_wr_data_pump: RTL and testbench

Transmit-side data pump of the HyperBus controller: the write-path counterpart of the RWDS-domain receive buffer. It accepts 16-bit write words with byte strobes from the AXI-side datapath, buffers them in a small synchronous FIFO, and, once the command FSM starts a write data phase, emits exactly one word per `clk` cycle toward the DDR output stage together with the RWDS byte mask. HyperBus writes cannot stall, so an upstream underrun is filled with fully masked dummy words and flagged.

---
 rtl/hb_wr_data_pump_pkg.sv | 23 ++
 rtl/hb_sync_fifo.sv | 60 ++++++
 rtl/hb_wr_data_pump.sv | 140 ++++++++++++++
 tb/tb_hb_wr_data_pump.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_wr_data_pump_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hb_wr_data_pump_pkg: shared HyperBus write-path encodings and limits.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hb_wr_data_pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } hb_state_e;

  localparam logic [1:0] HB_MASK_ALL        = 2'b11;
  localparam int         HB_MAX_BURST_WORDS = 256;

  // Words that must be buffered before a phase of rem words may start.
  function automatic logic [8:0] hb_prime_target(input logic [8:0] rem, input logic [8:0] lvl);
    return (rem < lvl) ? rem : lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hb_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hb_sync_fifo: single-clock show-ahead FIFO with full/empty/fill flags.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hb_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_fill
);

  localparam int             C_AW  = $clog2(DEPTH);
  localparam logic [C_AW:0]  C_ONE = (C_AW+1)'(1);
  localparam logic [C_AW:0]  C_MAX = (C_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW:0]    r_fill;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_fill == C_MAX);
  assign o_empty   = (r_fill == '0);
  assign o_fill    = r_fill;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + C_ONE;
        2'b01:   r_fill <= r_fill - C_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hb_wr_data_pump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hb_wr_data_pump: buffers write words and streams one word per cycle to   |
// | the DDR output stage, padding upstream underruns with masked dummies.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hb_wr_data_pump
  import hb_wr_data_pump_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [15:0] din,
  input  logic [1:0]  din_strb,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        tx_start,
  input  logic [8:0]  tx_len,
  output logic        tx_busy,
  output logic [15:0] dout,
  output logic [1:0]  dout_mask,
  output logic        dout_vld,
  output logic        tx_done,
  output logic        underrun
);

  localparam int          C_AW        = $clog2(DEPTH);
  localparam logic [8:0]  C_PRIME_LVL = 9'(PRIME_LVL);

  logic [17:0]   w_fifo_rd;
  logic          w_full;
  logic          w_empty;
  logic [C_AW:0] w_fill;

  hb_state_e     r_state;
  hb_state_e     w_state_nxt;
  logic [8:0]    r_rem;
  logic [8:0]    w_rem_nxt;
  logic          w_pop;
  logic          w_issue;
  logic          w_issue_last;
  logic [15:0]   w_issue_data;
  logic [1:0]    w_issue_mask;
  logic          w_set_under;
  logic          w_clr_under;

  logic [15:0]   r_dout;
  logic [1:0]    r_dout_mask;
  logic          r_dout_vld;
  logic          r_tx_done;
  logic          r_underrun;

  hb_sync_fifo #(.WIDTH(18), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .srst      (srst),
    .i_wr_en   (din_vld),
    .i_wr_data ({din_strb, din}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_fill    (w_fill)
  );

  assign din_rdy   = ~w_full;
  assign tx_busy   = (r_state != ST_IDLE);
  assign dout      = r_dout;
  assign dout_mask = r_dout_mask;
  assign dout_vld  = r_dout_vld;
  assign tx_done   = r_tx_done;
  assign underrun  = r_underrun;

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_data = 16'h0000;
    w_issue_mask = HB_MASK_ALL;
    w_set_under  = 1'b0;
    w_clr_under  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_start && (tx_len != 9'd0)) begin
          w_rem_nxt   = tx_len;
          w_clr_under = 1'b1;
          w_state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (9'(w_fill) >= hb_prime_target(r_rem, C_PRIME_LVL)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The bus cannot stall: an empty FIFO yields a fully masked dummy word.
        w_issue   = 1'b1;
        w_rem_nxt = r_rem - 9'd1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_issue_data = w_fifo_rd[15:0];
          w_issue_mask = ~w_fifo_rd[17:16];
        end else begin
          w_set_under  = 1'b1;
        end
        if (r_rem == 9'd1) begin
          w_issue_last = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state     <= ST_IDLE;
      r_rem       <= 9'd0;
      r_dout      <= 16'h0000;
      r_dout_mask <= HB_MASK_ALL;
      r_dout_vld  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_dout_vld <= w_issue;
      r_tx_done  <= w_issue_last;
      if (w_issue) begin
        r_dout      <= w_issue_data;
        r_dout_mask <= w_issue_mask;
      end
      if (w_clr_under)      r_underrun <= 1'b0;
      else if (w_set_under) r_underrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hb_wr_data_pump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hb_wr_data_pump: randomized self-checking bench with a queue model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hb_wr_data_pump;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] din;
  logic [1:0]  din_strb;
  logic        din_vld;
  logic        din_rdy;
  logic        tx_start;
  logic [8:0]  tx_len;
  logic        tx_busy;
  logic [15:0] dout;
  logic [1:0]  dout_mask;
  logic        dout_vld;
  logic        tx_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  logic [17:0] q[$];
  logic [15:0] got_d[$];
  logic [1:0]  got_m[$];
  logic        got_u[$];
  logic [15:0] exp_d[$];
  logic [1:0]  exp_m[$];
  logic        exp_u[$];
  int          first_lat;
  int          done_cnt;
  int          done_idx;
  int          gap_cnt;
  bit          timed_out;

  always #5 clk = ~clk;

  hb_wr_data_pump #(.DEPTH(DEPTH), .PRIME_LVL(4)) dut (
    .clk(clk), .srst(srst), .din(din), .din_strb(din_strb), .din_vld(din_vld),
    .din_rdy(din_rdy), .tx_start(tx_start), .tx_len(tx_len), .tx_busy(tx_busy),
    .dout(dout), .dout_mask(dout_mask), .dout_vld(dout_vld), .tx_done(tx_done),
    .underrun(underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic [1:0] s);
    bit acc;
    acc      = (q.size() < DEPTH);
    din      = d;
    din_strb = s;
    din_vld  = 1'b1;
    checks++;
    if (din_rdy !== acc) begin
      errors++;
      $display("FAIL push_rdy got %b exp %b", din_rdy, acc);
    end
    tick();
    if (acc) q.push_back({s, d});
    din_vld = 1'b0;
  endtask

  task automatic start(input logic [8:0] n);
    tx_start = 1'b1;
    tx_len   = n;
    tick();
    tx_start = 1'b0;
    tx_len   = 9'd0;
  endtask

  // Records every output word until tx_done; k counts cycles after the accepting edge.
  task automatic collect(input int budget, input int k0, input int poke_at, input logic [8:0] chain_len);
    int k;
    bit prev;
    bit fin;
    got_d.delete(); got_m.delete(); got_u.delete();
    first_lat = -1; done_cnt = 0; done_idx = -1; gap_cnt = 0;
    k = k0; prev = 1'b0; fin = 1'b0;
    while (!fin && k <= budget) begin
      if (k == poke_at) begin
        tx_start = 1'b1;
        tx_len   = 9'd3;
      end
      if (dout_vld === 1'b1) begin
        if (first_lat < 0) first_lat = k;
        else if (!prev) gap_cnt++;
        got_d.push_back(dout);
        got_m.push_back(dout_mask);
        got_u.push_back(underrun);
        if (tx_done === 1'b1) begin
          done_cnt++;
          done_idx = got_d.size();
          fin = 1'b1;
          if (chain_len != 9'd0) begin
            tx_start = 1'b1;
            tx_len   = chain_len;
          end
        end
      end else if (tx_done === 1'b1) begin
        done_cnt++;
      end
      prev = dout_vld;
      tick();
      tx_start = 1'b0;
      tx_len   = 9'd0;
      k++;
    end
    timed_out = !fin;
  endtask

  // Reference: a phase consumes queued words in order, padding with masked zeros.
  task automatic model_phase(input int n);
    logic [17:0] w;
    bit und;
    exp_d.delete(); exp_m.delete(); exp_u.delete();
    und = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (q.size() > 0) begin
        w = q.pop_front();
        exp_d.push_back(w[15:0]);
        exp_m.push_back(~w[17:16]);
      end else begin
        und = 1'b1;
        exp_d.push_back(16'h0000);
        exp_m.push_back(2'b11);
      end
      exp_u.push_back(und);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick(); tick();
    checks++;
    if ({dout, dout_mask, dout_vld, tx_done, underrun, tx_busy} !== {16'h0000, 2'b11, 4'b0000}) begin
      errors++;
      $display("FAIL reset_vals got %h/%b/%b%b%b%b exp 0000/11/0000", dout, dout_mask, dout_vld, tx_done, underrun, tx_busy);
    end
    srst = 1'b0;
    tick();
    checks++;
    if (din_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", din_rdy); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) push_word(16'(i * 16'h1111), 2'b11);
    start(9'd4);
    collect(20, 1, 0, 9'd0);
    model_phase(4);
    checks++;
    if (timed_out || first_lat != 3 || got_d.size() != 4 || done_cnt != 1 || done_idx != 4 || gap_cnt != 0) begin
      errors++;
      $display("FAIL basic_timing got lat %0d n %0d done %0d@%0d gaps %0d exp lat 3 n 4 done 1@4 gaps 0",
               first_lat, got_d.size(), done_cnt, done_idx, gap_cnt);
    end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i]) begin
        errors++;
        $display("FAIL basic_word%0d got %h/%b exp %h/%b", i, got_d[i], got_m[i], exp_d[i], exp_m[i]);
      end
    end
    checks++;
    if (underrun !== 1'b0 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL basic_end got und %b busy %b exp 0 0", underrun, tx_busy);
    end
  endtask

  task automatic test_prime_wait();
    start(9'd2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_busy !== 1'b1 || dout_vld !== 1'b0) begin
        errors++; $display("FAIL prime_hold%0d got busy %b vld %b exp 1 0", i, tx_busy, dout_vld);
      end
      tick();
    end
    push_word(16'hAAAA, 2'b01);
    checks++;
    if (dout_vld !== 1'b0 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL prime_one_word got vld %b busy %b exp 0 1", dout_vld, tx_busy);
    end
    push_word(16'hBBBB, 2'b11);
    collect(20, 1, 0, 9'd0);
    model_phase(2);
    checks++;
    if (timed_out || first_lat != 3 || got_d.size() != 2 || done_idx != 2) begin
      errors++; $display("FAIL prime_timing got lat %0d n %0d done@%0d exp lat 3 n 2 done@2", first_lat, got_d.size(), done_idx);
    end
    for (int i = 0; i < 2 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i]) begin
        errors++; $display("FAIL prime_word%0d got %h/%b exp %h/%b", i, got_d[i], got_m[i], exp_d[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 4; i++) push_word(16'($urandom), 2'($urandom_range(0, 3)));
    start(9'd8);
    collect(30, 1, 0, 9'd0);
    model_phase(8);
    checks++;
    if (timed_out || got_d.size() != 8 || done_cnt != 1 || done_idx != 8 || gap_cnt != 0) begin
      errors++; $display("FAIL under_count got n %0d done %0d@%0d gaps %0d exp n 8 done 1@8 gaps 0", got_d.size(), done_cnt, done_idx, gap_cnt);
    end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i] || got_u[i] !== exp_u[i]) begin
        errors++; $display("FAIL under_word%0d got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_m[i], got_u[i], exp_d[i], exp_m[i], exp_u[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] wd [2];
    logic [1:0]  ws [2];
    int rdy_first;
    for (int i = 0; i < 8; i++) push_word(16'($urandom), 2'($urandom_range(0, 3)));
    checks++;
    if (din_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", din_rdy); end
    for (int i = 0; i < 2; i++) begin wd[i] = 16'($urandom); ws[i] = 2'($urandom_range(0, 3)); end
    rdy_first = -1;
    din = wd[0]; din_strb = ws[0]; din_vld = 1'b1;
    start(9'd10);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL full_und_clr got %b exp 0", underrun); end
    fork
      collect(40, 1, 0, 9'd0);
      begin
        int k;
        int acc_n;
        bit rdy;
        k = 1; acc_n = 0;
        while (acc_n < 2 && k < 40) begin
          rdy = din_rdy;
          if (rdy && rdy_first < 0) rdy_first = k;
          tick();
          if (rdy) begin
            q.push_back({din_strb, din});
            acc_n++;
            if (acc_n < 2) begin din = wd[acc_n]; din_strb = ws[acc_n]; end
          end
          k++;
        end
        din_vld = 1'b0;
      end
    join
    model_phase(10);
    checks++;
    if (timed_out || rdy_first != 3 || got_d.size() != 10 || done_idx != 10 || gap_cnt != 0) begin
      errors++; $display("FAIL full_timing got rdy@%0d n %0d done@%0d gaps %0d exp rdy@3 n 10 done@10 gaps 0", rdy_first, got_d.size(), done_idx, gap_cnt);
    end
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i] || got_u[i] !== 1'b0) begin
        errors++; $display("FAIL full_word%0d got %h/%b/%b exp %h/%b/0", i, got_d[i], got_m[i], got_u[i], exp_d[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_srst_mid();
    for (int i = 0; i < 4; i++) push_word(16'($urandom), 2'($urandom_range(0, 3)));
    start(9'd8);
    tick(); tick(); tick();
    srst = 1'b1;
    tick();
    checks++;
    if (dout_vld !== 1'b0 || tx_busy !== 1'b0 || dout_mask !== 2'b11 || tx_done !== 1'b0) begin
      errors++; $display("FAIL srst_mid got vld %b busy %b mask %b done %b exp 0 0 11 0", dout_vld, tx_busy, dout_mask, tx_done);
    end
    srst = 1'b0;
    q.delete();
    tick();
    start(9'd1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx_busy !== 1'b1 || dout_vld !== 1'b0 || tx_done !== 1'b0) begin
        errors++; $display("FAIL srst_flush%0d got busy %b vld %b done %b exp 1 0 0", i, tx_busy, dout_vld, tx_done);
      end
      tick();
    end
    push_word(16'($urandom), 2'($urandom_range(0, 3)));
    collect(20, 1, 0, 9'd0);
    model_phase(1);
    checks++;
    if (timed_out || first_lat != 3 || got_d.size() != 1 || got_d[0] !== exp_d[0] || got_m[0] !== exp_m[0]) begin
      errors++; $display("FAIL srst_after got lat %0d n %0d exp lat 3 n 1 word %h/%b", first_lat, got_d.size(), exp_d[0], exp_m[0]);
    end
  endtask

  task automatic test_ignored();
    tx_start = 1'b1; tx_len = 9'd0;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_busy !== 1'b0 || dout_vld !== 1'b0) begin
        errors++; $display("FAIL len0_ignored%0d got busy %b vld %b exp 0 0", i, tx_busy, dout_vld);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) push_word(16'($urandom), 2'($urandom_range(0, 3)));
    start(9'd5);
    collect(30, 1, 3, 9'd0);
    model_phase(5);
    checks++;
    if (timed_out || got_d.size() != 5 || done_idx != 5 || done_cnt != 1) begin
      errors++; $display("FAIL run_start_ignored got n %0d done %0d@%0d exp n 5 done 1@5", got_d.size(), done_cnt, done_idx);
    end
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i]) begin
        errors++; $display("FAIL ign_word%0d got %h/%b exp %h/%b", i, got_d[i], got_m[i], exp_d[i], exp_m[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_busy !== 1'b0 || dout_vld !== 1'b0) begin
        errors++; $display("FAIL ign_after%0d got busy %b vld %b exp 0 0", i, tx_busy, dout_vld);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    while (q.size() < 8) push_word(16'($urandom), 2'($urandom_range(0, 3)));
    start(9'd3);
    collect(20, 1, 0, 9'd4);
    model_phase(3);
    checks++;
    if (timed_out || got_d.size() != 3 || done_idx != 3) begin
      errors++; $display("FAIL b2b_first got n %0d done@%0d exp n 3 done@3", got_d.size(), done_idx);
    end
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i]) begin
        errors++; $display("FAIL b2b_a%0d got %h/%b exp %h/%b", i, got_d[i], got_m[i], exp_d[i], exp_m[i]);
      end
    end
    collect(20, 1, 0, 9'd0);
    model_phase(4);
    checks++;
    if (timed_out || first_lat != 3 || got_d.size() != 4 || done_idx != 4) begin
      errors++; $display("FAIL b2b_second got lat %0d n %0d done@%0d exp lat 3 n 4 done@4", first_lat, got_d.size(), done_idx);
    end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i]) begin
        errors++; $display("FAIL b2b_b%0d got %h/%b exp %h/%b", i, got_d[i], got_m[i], exp_d[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int tgt;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 16);
      tgt = $urandom_range((n < 4) ? n : 4, DEPTH);
      while (q.size() < tgt) push_word(16'($urandom), 2'($urandom_range(0, 3)));
      start(9'(n));
      collect(n + 20, 1, 0, 9'd0);
      model_phase(n);
      checks++;
      if (timed_out || first_lat != 3 || got_d.size() != n || done_cnt != 1 || done_idx != n || gap_cnt != 0) begin
        errors++; $display("FAIL rand%0d_timing got lat %0d n %0d done %0d@%0d gaps %0d exp lat 3 n %0d done 1@%0d",
                           it, first_lat, got_d.size(), done_cnt, done_idx, gap_cnt, n, n);
      end
      for (int i = 0; i < n && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_m[i] !== exp_m[i] || got_u[i] !== exp_u[i]) begin
          errors++; $display("FAIL rand%0d_word%0d got %h/%b/%b exp %h/%b/%b", it, i, got_d[i], got_m[i], got_u[i], exp_d[i], exp_m[i], exp_u[i]);
        end
      end
    end
  endtask

  initial begin
    srst = 1'b1; din = 16'h0; din_strb = 2'b00; din_vld = 1'b0;
    tx_start = 1'b0; tx_len = 9'd0;
    test_reset();
    test_basic();
    test_prime_wait();
    test_underrun();
    test_full();
    test_srst_mid();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
